// File: rtl/pacman_pkg.sv
// Shared types and defaults for the Pac-Man game controller: state encoding,
// default point/frame constants and small saturating arithmetic helpers.
package pacman_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_POWER     = 3'd2,
    ST_DYING     = 3'd3,
    ST_WIN       = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  localparam int unsigned DEF_LIVES_INIT   = 3;
  localparam int unsigned DEF_TOTAL_DOTS   = 64;
  localparam int unsigned DEF_POWER_FRAMES = 180;
  localparam int unsigned DEF_DYING_FRAMES = 60;
  localparam int unsigned DEF_DOT_PTS      = 10;
  localparam int unsigned DEF_PWR_PTS      = 50;
  localparam int unsigned DEF_GHOST_PTS    = 200;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [7:0] dec_floor8(input logic [7:0] a);
    return (a == 8'd0) ? 8'd0 : a - 8'd1;
  endfunction

endpackage

// File: rtl/pacman_game_fsm_frame_event_latch.sv
// Sticky per-frame collision latch: any high cycle sets it, startOfFrame hands
// the latched event to the game logic and restarts with that cycle's input.
module frame_event_latch (
  input  logic clk,
  input  logic reset,
  input  logic sof_i,
  input  logic col_i,
  output logic event_o
);

  logic hit_q, hit_d;

  // A hit on the frame boundary itself belongs to the frame that is starting.
  always_comb begin
    hit_d = 1'b0;
    if (sof_i) begin
      hit_d = col_i;
    end else begin
      hit_d = hit_q | col_i;
    end
  end

  // Latch register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign event_o = hit_q;

endmodule

// File: rtl/pacman_game_fsm.sv
// Pac-Man game-state controller: consumes one latched collision event per kind
// each frame and maintains state, score, lives, remaining dots and timers.
module pacman_game_fsm
  import pacman_pkg::*;
#(
  parameter int unsigned LIVES_INIT   = DEF_LIVES_INIT,
  parameter int unsigned TOTAL_DOTS   = DEF_TOTAL_DOTS,
  parameter int unsigned POWER_FRAMES = DEF_POWER_FRAMES,
  parameter int unsigned DYING_FRAMES = DEF_DYING_FRAMES,
  parameter int unsigned DOT_PTS      = DEF_DOT_PTS,
  parameter int unsigned PWR_PTS      = DEF_PWR_PTS,
  parameter int unsigned GHOST_PTS    = DEF_GHOST_PTS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        col_dot,
  input  logic        col_power,
  input  logic        col_ghost,
  output logic [2:0]  state,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic [7:0]  dots_left,
  output logic        power_active,
  output logic        freeze,
  output logic        ghost_eaten_pulse,
  output logic        death_pulse
);

  localparam logic [1:0]  LIVES_L = 2'(LIVES_INIT);
  localparam logic [7:0]  DOTS_L  = 8'(TOTAL_DOTS);
  localparam logic [15:0] POWER_T = 16'(POWER_FRAMES);
  localparam logic [15:0] DYING_T = 16'(DYING_FRAMES);
  localparam logic [15:0] DOT_L   = 16'(DOT_PTS);
  localparam logic [15:0] PWR_L   = 16'(PWR_PTS);
  localparam logic [15:0] GHOST_L = 16'(GHOST_PTS);

  state_e      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  dots_q, dots_d;
  logic [15:0] timer_q, timer_d;
  logic        start_prev_q;
  logic        ghost_pulse_q, ghost_pulse_d;
  logic        death_pulse_q, death_pulse_d;
  logic        freeze_q, freeze_d;
  logic        power_q, power_d;
  logic        ev_dot, ev_power, ev_ghost;
  logic        start_rise;

  frame_event_latch u_dot_latch (
    .clk(clk), .reset(reset), .sof_i(startOfFrame), .col_i(col_dot), .event_o(ev_dot)
  );
  frame_event_latch u_power_latch (
    .clk(clk), .reset(reset), .sof_i(startOfFrame), .col_i(col_power), .event_o(ev_power)
  );
  frame_event_latch u_ghost_latch (
    .clk(clk), .reset(reset), .sof_i(startOfFrame), .col_i(col_ghost), .event_o(ev_ghost)
  );

  assign start_rise = start_key & ~start_prev_q;

  // Next-state and per-frame bookkeeping.
  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    lives_d       = lives_q;
    dots_d        = dots_q;
    timer_d       = timer_q;
    ghost_pulse_d = 1'b0;
    death_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_PLAY;
          score_d = 16'd0;
          lives_d = LIVES_L;
          dots_d  = DOTS_L;
          timer_d = 16'd0;
        end
      end
      ST_PLAY: begin
        if (startOfFrame) begin
          // A death swallows whatever else was collected that frame.
          if (ev_ghost) begin
            lives_d       = lives_q - 2'd1;
            death_pulse_d = 1'b1;
            if (lives_d != 2'd0) begin
              state_d = ST_DYING;
              timer_d = DYING_T;
            end else begin
              state_d = ST_GAME_OVER;
              timer_d = 16'd0;
            end
          end else if (ev_power) begin
            score_d = sat_add16(score_q, PWR_L);
            dots_d  = dec_floor8(dots_q);
            timer_d = POWER_T;
            state_d = (dots_d == 8'd0) ? ST_WIN : ST_POWER;
          end else if (ev_dot) begin
            score_d = sat_add16(score_q, DOT_L);
            dots_d  = dec_floor8(dots_q);
            state_d = (dots_d == 8'd0) ? ST_WIN : ST_PLAY;
          end
        end
      end
      ST_POWER: begin
        if (startOfFrame) begin
          if (ev_ghost) begin
            score_d       = sat_add16(score_d, GHOST_L);
            ghost_pulse_d = 1'b1;
          end
          if (ev_dot) begin
            score_d = sat_add16(score_d, DOT_L);
            dots_d  = dec_floor8(dots_d);
          end
          if (ev_power) begin
            score_d = sat_add16(score_d, PWR_L);
            dots_d  = dec_floor8(dots_d);
            timer_d = POWER_T;
          end else if (timer_q <= 16'd1) begin
            timer_d = 16'd0;
            state_d = ST_PLAY;
          end else begin
            timer_d = timer_q - 16'd1;
          end
          if (dots_d == 8'd0) begin
            state_d = ST_WIN;
            timer_d = 16'd0;
          end
        end
      end
      ST_DYING: begin
        if (startOfFrame) begin
          if (timer_q <= 16'd1) begin
            timer_d = 16'd0;
            state_d = ST_PLAY;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
      end
      ST_WIN: begin
        if (start_rise) begin
          state_d = ST_PLAY;
          dots_d  = DOTS_L;
        end
      end
      ST_GAME_OVER: begin
        if (start_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    freeze_d = (state_d != ST_PLAY) && (state_d != ST_POWER);
    power_d  = (state_d == ST_POWER);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      score_q       <= 16'd0;
      lives_q       <= LIVES_L;
      dots_q        <= DOTS_L;
      timer_q       <= 16'd0;
      start_prev_q  <= 1'b0;
      ghost_pulse_q <= 1'b0;
      death_pulse_q <= 1'b0;
      freeze_q      <= 1'b1;
      power_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      dots_q        <= dots_d;
      timer_q       <= timer_d;
      start_prev_q  <= start_key;
      ghost_pulse_q <= ghost_pulse_d;
      death_pulse_q <= death_pulse_d;
      freeze_q      <= freeze_d;
      power_q       <= power_d;
    end
  end

  assign state             = state_q;
  assign score             = score_q;
  assign lives             = lives_q;
  assign dots_left         = dots_q;
  assign power_active      = power_q;
  assign freeze            = freeze_q;
  assign ghost_eaten_pulse = ghost_pulse_q;
  assign death_pulse       = death_pulse_q;

endmodule
